// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Four-digit multiplexed seven-segment scan driver. Packed BCD digits and
// decimal points are captured on a load strobe into a shadow register, then
// time-multiplexed onto one shared active-low segment bus and four active-low
// anode enables. Optional leading-zero blanking, whole-display blinking and a
// one-cycle ghost-guard at the start of every digit slot.
//
// Ports:
//   clk         system clock
//   rst_n       synchronous reset, ACTIVE-HIGH despite the name
//   bcd_in      four BCD digits, [3:0] = digit0 (rightmost) .. [15:12] = digit3
//   dp_in       decimal point request per digit, 1 = lit
//   load        capture strobe for bcd_in/dp_in, level-sampled every clk
//   blank_lz    1 = suppress leading zeros
//   blink       1 = blink the whole display
//   seg         segments {a,b,c,d,e,f,g}, 0 = lit
//   dp          decimal point, 0 = lit
//   anode       digit enables, 0 = enabled, bit i = digit i
//   frame_done  one-cycle pulse at the end of each digit3 slot
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV = 50000,  // clocks per digit slot, >= 2
  parameter int unsigned BLINK_DIV   = 125     // slots per blink half-period, >= 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
  input  logic        blink,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  anode,
  output logic        frame_done
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  // +1 keeps the width non-zero when BLINK_DIV is 1.
  localparam int unsigned BW = $clog2(BLINK_DIV + 1);

  localparam logic [PW-1:0] PRE_MAX  = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BCNT_MAX = BW'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Active-low decode; non-BCD nibbles go dark.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  // State registers
  logic [PW-1:0] pre_q,     pre_d;
  logic [1:0]    idx_q,     idx_d;
  logic [BW-1:0] bcnt_q,    bcnt_d;
  logic          phase_q,   phase_d;
  logic [15:0]   shd_bcd_q, shd_bcd_d;
  logic [3:0]    shd_dp_q,  shd_dp_d;

  // Output registers
  logic [6:0]    seg_q,     seg_d;
  logic          dp_q,      dp_d;
  logic [3:0]    anode_q,   anode_d;
  logic          fdone_q,   fdone_d;

  logic          tick;
  logic [3:0]    digit;
  logic [3:0]    lz_blank;

  assign tick  = (pre_q == PRE_MAX);
  assign digit = shd_bcd_q[{idx_q, 2'b00} +: 4];

  // Digit i is a leading zero when it and every digit above it are zero.
  // Digit0 always shows, so a value of zero still displays "0".
  always_comb begin
    lz_blank[3] = (shd_bcd_q[15:12] == 4'h0);
    lz_blank[2] = lz_blank[3] && (shd_bcd_q[11:8] == 4'h0);
    lz_blank[1] = lz_blank[2] && (shd_bcd_q[7:4]  == 4'h0);
    lz_blank[0] = 1'b0;
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    pre_d     = tick ? '0 : pre_q + 1'b1;
    idx_d     = idx_q;
    bcnt_d    = bcnt_q;
    phase_d   = phase_q;
    shd_bcd_d = shd_bcd_q;
    shd_dp_d  = shd_dp_q;
    seg_d     = SEG_OFF;
    dp_d      = 1'b1;
    anode_d   = 4'b1111;
    fdone_d   = tick && (idx_q == 2'd3);

    if (tick) idx_d = idx_q + 2'd1;

    // Blink counts slot ticks only while requested; dropping blink clears
    // the phase so the display comes straight back.
    if (!blink) begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      if (bcnt_q == BCNT_MAX) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d  = bcnt_q + 1'b1;
      end
    end

    if (load) begin
      shd_bcd_d = bcd_in;
      shd_dp_d  = dp_in;
    end

    // First cycle of each slot is dark so the previous digit's segments do
    // not ghost onto the newly enabled anode.
    if ((pre_q != '0) && !phase_q) begin
      anode_d = ~(4'b0001 << idx_q);
      if (blank_lz && lz_blank[idx_q]) begin
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
      end else begin
        seg_d = decode(digit);
        dp_d  = ~shd_dp_q[idx_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_n) begin
      pre_q     <= '0;
      idx_q     <= '0;
      bcnt_q    <= '0;
      phase_q   <= 1'b0;
      shd_bcd_q <= 16'h0000;
      shd_dp_q  <= 4'h0;
      seg_q     <= SEG_OFF;
      dp_q      <= 1'b1;
      anode_q   <= 4'b1111;
      fdone_q   <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      bcnt_q    <= bcnt_d;
      phase_q   <= phase_d;
      shd_bcd_q <= shd_bcd_d;
      shd_dp_q  <= shd_dp_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      anode_q   <= anode_d;
      fdone_q   <= fdone_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign anode      = anode_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Self-checking bench for seg7_scan_driver with REFRESH_DIV=4, BLINK_DIV=2.
// A behavioural model derives the expected display from the number of cycles
// since reset (slot = cycles / REFRESH_DIV, digit = slot mod 4), the number
// of slot ticks seen while blink has been held, and a copy of the loaded
// value. Directed steps cover each behaviour, then randomized traffic runs.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int RD = 4;
  localparam int BD = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic        blink;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  anode;
  logic        frame_done;

  seg7_scan_driver #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .blink      (blink),
    .seg        (seg),
    .dp         (dp),
    .anode      (anode),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          m_cyc;     // edges since last reset
  int          m_bt;      // slot ticks seen while blink held
  logic [15:0] m_bcd;
  logic [3:0]  m_dp;
  logic [6:0]  seg_tab [16];

  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [3:0]  exp_anode;
  logic        exp_fd;

  task automatic check_outputs();
    checks++;
    assert (seg === exp_seg) else begin
      failures++;
      $error("FAIL seg cyc=%0d observed=%b expected=%b", m_cyc, seg, exp_seg);
    end
    checks++;
    assert (dp === exp_dp) else begin
      failures++;
      $error("FAIL dp cyc=%0d observed=%b expected=%b", m_cyc, dp, exp_dp);
    end
    checks++;
    assert (anode === exp_anode) else begin
      failures++;
      $error("FAIL anode cyc=%0d observed=%b expected=%b", m_cyc, anode, exp_anode);
    end
    checks++;
    assert (frame_done === exp_fd) else begin
      failures++;
      $error("FAIL frame_done cyc=%0d observed=%b expected=%b", m_cyc, frame_done, exp_fd);
    end
  endtask

  // One clock: predict the outputs from the pre-edge model and the current
  // inputs, advance the model, clock the DUT, then compare.
  task automatic step();
    int  pos, slot, d;
    bit  tick, dark, lz;
    pos  = m_cyc % RD;
    slot = (m_cyc / RD) % 4;
    tick = (pos == RD - 1);
    dark = (pos == 0) || (((m_bt / BD) % 2) == 1);

    if (rst_n) begin
      exp_seg = 7'h7F; exp_dp = 1'b1; exp_anode = 4'hF; exp_fd = 1'b0;
      m_cyc = 0; m_bt = 0; m_bcd = 16'h0; m_dp = 4'h0;
    end else begin
      exp_fd = tick && (slot == 3);
      if (dark) begin
        exp_seg = 7'h7F; exp_dp = 1'b1; exp_anode = 4'hF;
      end else begin
        exp_anode = 4'hF;
        exp_anode[slot] = 1'b0;
        d  = (m_bcd >> (4 * slot)) & 15;
        lz = blank_lz && (slot >= 1) && ((m_bcd >> (4 * slot)) == 0);
        exp_seg = lz ? 7'h7F : seg_tab[d];
        exp_dp  = lz ? 1'b1  : ~m_dp[slot];
      end
      m_cyc++;
      if (!blink)    m_bt = 0;
      else if (tick) m_bt++;
      if (load) begin
        m_bcd = bcd_in;
        m_dp  = dp_in;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] p);
    bcd_in = v; dp_in = p; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111;
    seg_tab[2] = 7'b0010010; seg_tab[3] = 7'b0000110;
    seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
    seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111;
    seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0000100;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b1111111;

    m_cyc = 0; m_bt = 0; m_bcd = '0; m_dp = '0;
    rst_n = 1'b1; bcd_in = '0; dp_in = '0; load = 1'b0;
    blank_lz = 1'b0; blink = 1'b0;

    // Reset state
    run(2);
    rst_n = 1'b0;

    // Basic scan of 0042, two full frames
    do_load(16'h0042, 4'b0000);
    run(32);

    // Leading-zero blanking
    blank_lz = 1'b1;
    run(16);
    do_load(16'h0000, 4'b0000);
    run(16);
    do_load(16'h1000, 4'b0000);
    run(16);

    // Non-BCD nibble and decimal point
    do_load(16'h0A07, 4'b0010);
    run(16);
    blank_lz = 1'b0;

    // Blink: two slots lit, two slots dark, alternating
    do_load(16'h1234, 4'b0000);
    blink = 1'b1;
    run(48);
    blink = 1'b0;
    run(16);

    // bcd_in changes without load are ignored
    bcd_in = 16'h9876; dp_in = 4'hF;
    run(8);
    // Single-cycle load in the middle of a slot
    run(2);
    do_load(16'h5555, 4'b0101);
    run(10);

    // Reset during digit2, pre=2, with load held high
    for (int k = 0; k < 16 && (m_cyc % 16) != 10; k++) step();
    rst_n = 1'b1; bcd_in = 16'h8888; dp_in = 4'hF; load = 1'b1;
    step();
    rst_n = 1'b0; load = 1'b0;
    run(20);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [15:0] v;
      for (int n = 0; n < 4; n++)
        v[4*n +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      bcd_in = v;
      dp_in  = 4'($urandom_range(0, 15));
      load   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 39) == 0) blink = ~blink;
      rst_n  = ($urandom_range(0, 149) == 0);
      step();
    end
    rst_n = 1'b0; load = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
